// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 sequence detector and its detection logger.
package seq_det_pkg;

  localparam int TS_WIDTH_DEF  = 16;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_WIDTH_DEF = 8;

  // Detector states: S0 idle, S1 seen "1", S2 seen "10", S3 seen "101".
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push on a full FIFO is accepted
// only when a pop happens in the same cycle. dout reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Accepted push/pop and next pointer values.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the array is not reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/seq_det_logger.sv
// Timestamps detector pulses against a free-running counter, buffers them in a
// FIFO for host readout, and keeps a saturating count plus a sticky overflow.
module seq_det_logger
  import seq_det_pkg::*;
#(
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 det,
  input  logic                 clr,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [TS_WIDTH-1:0]  rd_ts,
  output logic [CNT_WIDTH-1:0] total_cnt,
  output logic                 overflow
);

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] total_cnt_q, total_cnt_d;
  logic                 overflow_q, overflow_d;

  logic capture, fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

  // Capture/pop gating, drop decision and next-state for counters and flag.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    capture     = en && det;
    fifo_flush  = rst || clr;
    fifo_push   = capture && !clr;
    fifo_pop    = rd_ready && !fifo_empty && !clr;
    ts_d        = ts_q;
    total_cnt_d = total_cnt_q;
    overflow_d  = overflow_q;
    if (clr) begin
      ts_d        = '0;
      total_cnt_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (en) ts_d = ts_q + TS_WIDTH'(1);
      if (capture) begin
        if (total_cnt_q != '1) total_cnt_d = total_cnt_q + CNT_WIDTH'(1);
        if (fifo_full && !fifo_pop) overflow_d = 1'b1;
      end
    end
  end

  // Timestamp, detection count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      total_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      total_cnt_q <= total_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ts_q),
    .dout  (rd_ts),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_valid  = !fifo_empty;
  assign total_cnt = total_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_det_logger.sv
// Bench for seq_det_logger: scoreboard queue of expected timestamps, a monitor
// that checks every handshake, and a narrow instance for saturation and wrap.
module tb_seq_det_logger;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (16/4/8)
  logic        rst, en, det_drv, clr, rd_ready, rd_valid, overflow;
  logic        det;
  logic [15:0] rd_ts;
  logic [7:0]  total_cnt;

  // Narrow instance (TS 4, CNT 2)
  logic        s_en, s_det, s_clr, s_ready, s_rd_valid, s_overflow;
  logic [3:0]  s_rd_ts;
  logic [1:0]  s_total;

  // Reference 1011 Mealy detector used as a pulse source
  logic       x, use_fsm, det_fsm;
  det_state_e fsm_state;
  int         det_pulses;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_ts;
  logic [15:0] t0;

  assign det_fsm = (fsm_state == S3) && x;
  assign det     = det_drv | (use_fsm & det_fsm);

  seq_det_logger #(.TS_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .det(det), .clr(clr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ts(rd_ts),
    .total_cnt(total_cnt), .overflow(overflow)
  );

  seq_det_logger #(.TS_WIDTH(4), .DEPTH(4), .CNT_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .en(s_en), .det(s_det), .clr(s_clr),
    .rd_valid(s_rd_valid), .rd_ready(s_ready), .rd_ts(s_rd_ts),
    .total_cnt(s_total), .overflow(s_overflow)
  );

  always @(posedge clk) begin
    if (rst) fsm_state <= S0;
    else begin
      case (fsm_state)
        S0: fsm_state <= x ? S1 : S0;
        S1: fsm_state <= x ? S1 : S2;
        S2: fsm_state <= x ? S3 : S0;
        S3: fsm_state <= x ? S1 : S2;
        default: fsm_state <= S0;
      endcase
    end
    if (use_fsm && det_fsm) det_pulses <= det_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !clr && rd_valid && rd_ready) begin
      if (sb_q.size() == 0) check("pop_unexpected", 32'(rd_ts), 32'hFFFF_FFFF);
      else check("pop_ts", 32'(rd_ts), 32'(sb_q.pop_front()));
    end
  end

  // Advance one clock; exp_ts follows the timestamp rule for the main instance.
  task automatic tick();
    @(posedge clk);
    if (rst || clr) exp_ts = '0;
    else if (en) exp_ts = exp_ts + 16'd1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 1; det_drv = 0; clr = 0; rd_ready = 0;
    s_en = 0; s_det = 0; s_clr = 0; s_ready = 0;
    x = 0; use_fsm = 0; det_pulses = 0; exp_ts = '0;
    tick(); tick();
    rst = 0;
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_ts", 32'(rd_ts), 0);
    check("rst_total", 32'(total_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);

    // Basic capture at ts=5
    repeat (5) tick();
    det_drv = 1; sb_q.push_back(16'd5); tick(); det_drv = 0;
    check("cap_valid", 32'(rd_valid), 1);
    check("cap_ts", 32'(rd_ts), 5);
    check("cap_total", 32'(total_cnt), 1);
    rd_ready = 1; tick(); rd_ready = 0;
    check("cap_drained", 32'(rd_valid), 0);

    // Detector stream 1011011: pulses on bits 3 and 6, three cycles apart
    use_fsm = 1;
    for (int i = 0; i < 7; i++) begin
      logic [6:0] bits;
      bits = 7'b1011011;
      x = bits[6-i];
      if (i == 3) begin t0 = exp_ts; sb_q.push_back(t0); end
      if (i == 6) sb_q.push_back(t0 + 16'd3);
      tick();
    end
    x = 0; tick(); use_fsm = 0;
    check("fsm_pulses", 32'(det_pulses), 2);
    check("fsm_total", 32'(total_cnt), 3);
    rd_ready = 1; repeat (2) tick(); rd_ready = 0;
    check("fsm_drained", 32'(rd_valid), 0);

    // Fill to DEPTH with back-to-back detections
    for (int i = 0; i < 4; i++) begin
      det_drv = 1; sb_q.push_back(exp_ts); tick();
    end
    det_drv = 0;
    check("full_ovf", 32'(overflow), 0);
    check("full_total", 32'(total_cnt), 7);

    // Push and pop together while full: both succeed, no overflow
    det_drv = 1; rd_ready = 1; sb_q.push_back(exp_ts); tick();
    det_drv = 0; rd_ready = 0;
    check("pp_ovf", 32'(overflow), 0);
    check("pp_total", 32'(total_cnt), 8);
    check("pp_valid", 32'(rd_valid), 1);

    // Detection into a full FIFO is dropped but still counted
    det_drv = 1; tick(); det_drv = 0;
    check("drop_ovf", 32'(overflow), 1);
    check("drop_total", 32'(total_cnt), 9);

    // Exactly four entries remain
    rd_ready = 1; repeat (4) tick(); rd_ready = 0;
    check("drain_valid", 32'(rd_valid), 0);
    check("drain_left", 32'(sb_q.size()), 0);
    check("drain_ovf_sticky", 32'(overflow), 1);

    // Clear with det and rd_ready while 3 entries are pending
    for (int i = 0; i < 3; i++) begin
      det_drv = 1; sb_q.push_back(exp_ts); tick();
    end
    det_drv = 0;
    check("pre_clr_total", 32'(total_cnt), 12);
    clr = 1; det_drv = 1; rd_ready = 1; sb_q.delete(); tick();
    clr = 0; det_drv = 0; rd_ready = 0;
    check("clr_valid", 32'(rd_valid), 0);
    check("clr_total", 32'(total_cnt), 0);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_ts_out", 32'(rd_ts), 0);
    det_drv = 1; sb_q.push_back(16'd0); tick();
    sb_q.push_back(16'd1); tick(); det_drv = 0;
    check("clr_recap_total", 32'(total_cnt), 2);
    rd_ready = 1; repeat (2) tick(); rd_ready = 0;
    check("clr_recap_drained", 32'(rd_valid), 0);

    // Reset mid-operation behaves like clear
    for (int i = 0; i < 3; i++) begin
      det_drv = 1; sb_q.push_back(exp_ts); tick();
    end
    rst = 1; det_drv = 1; rd_ready = 1; sb_q.delete(); tick();
    rst = 0; det_drv = 0; rd_ready = 0;
    check("rst2_valid", 32'(rd_valid), 0);
    check("rst2_total", 32'(total_cnt), 0);
    check("rst2_ovf", 32'(overflow), 0);
    det_drv = 1; sb_q.push_back(16'd0); tick();
    sb_q.push_back(16'd1); tick(); det_drv = 0;
    rd_ready = 1; repeat (2) tick(); rd_ready = 0;
    check("rst2_drained", 32'(rd_valid), 0);
    check("sb_empty", 32'(sb_q.size()), 0);

    // Narrow instance: det with en=0 is ignored
    s_det = 1; tick(); s_det = 0;
    check("s_noen_valid", 32'(s_rd_valid), 0);
    check("s_noen_total", 32'(s_total), 0);
    check("s_noen_ovf", 32'(s_overflow), 0);

    // Five detections from ts=15: stored 15,0,1,2; count saturates at 3
    s_en = 1; repeat (15) tick();
    s_det = 1; repeat (5) tick(); s_det = 0;
    check("s_sat_total", 32'(s_total), 3);
    check("s_ovf", 32'(s_overflow), 1);
    check("s_head", 32'(s_rd_ts), 15);
    s_ready = 1;
    tick(); check("s_wrap0", 32'(s_rd_ts), 0);
    tick(); check("s_wrap1", 32'(s_rd_ts), 1);
    tick(); check("s_wrap2", 32'(s_rd_ts), 2);
    tick(); s_ready = 0;
    check("s_drained", 32'(s_rd_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_logger.md
# seq_det_logger

Downstream consumer of the 1011 sequence detector's one-cycle Mealy output pulse. It timestamps every detection against a free-running cycle counter and buffers the timestamps in a small FIFO. A host reads them out over a valid/ready handshake. It also keeps a saturating total-detection count and a sticky overflow flag.

## Interface

Parameters:
- TS_WIDTH, 16: width of the timestamp counter and of each FIFO entry.
- DEPTH, 4: number of FIFO entries; must be a power of two, 2 or greater.
- CNT_WIDTH, 8: width of the total-detection counter.

Ports:
- clk, in, 1: single clock. All state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: logger enable. Gates both timestamp advance and capture.
- det, in, 1: detection pulse, driven directly by the detector's y output.
- clr, in, 1: synchronous soft clear.
- rd_valid, out, 1: FIFO non-empty.
- rd_ready, in, 1: host accepts the head entry.
- rd_ts, out, TS_WIDTH: head timestamp. Reads 0 when the FIFO is empty.
- total_cnt, out, CNT_WIDTH: saturating count of captured detections.
- overflow, out, 1: sticky. Set when a detection is dropped because the FIFO is full.

## Operation

- **Timestamp counter `ts`**
  - Increments by 1 each cycle while en=1; holds while en=0.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- **Capture**
  - Triggered when det=1 and en=1 in cycle N.
  - The value of ts in cycle N (pre-increment) is pushed.
  - total_cnt increments and saturates at 2^CNT_WIDTH−1.
  - det while en=0 is ignored entirely: no push, no count, no overflow.
- **Pop**: occurs when rd_valid=1 and rd_ready=1. The head entry is removed at the clock edge.
- **Full FIFO**
  - A capture with no pop in the same cycle is dropped and overflow←1.
  - total_cnt still increments, since it counts detections rather than stored entries.
  - If a pop and a push coincide on a full FIFO, both succeed: occupancy stays DEPTH and no overflow is raised.
- **Empty FIFO**: rd_ready is ignored and pointers do not move.
- **clr**, priority over everything except rst:
  - Empties the FIFO and zeroes ts, total_cnt and overflow.
  - A det or pop in the same cycle is discarded.
- **rst**
  - Same effect as clr.
  - Reset values: rd_valid=0, rd_ts=0, total_cnt=0, overflow=0, ts=0.
  - An asserted rst mid-readout discards all pending entries.
- **Ordering**: entries leave in capture order (FIFO).
- **Detector input**: det is back-to-back capable. The detector can pulse on consecutive 1011 overlaps no closer than every 3 cycles, but the logger must accept det high every cycle.

## Timing

- **Capture latency**: det in cycle N into an empty FIFO gives rd_valid=1 and rd_ts = ts(N) in cycle N+1.
- **Pop**: handshake in cycle M; the next entry, or rd_valid=0, is visible in cycle M+1.
- **Throughput**: one push and one pop per cycle sustained.
- **Output sourcing**
  - rd_ts comes combinationally from registered storage and the read pointer.
  - rd_valid, total_cnt and overflow are registered or pointer-derived only.
  - No combinational path from det or rd_ready to any output.
- **Occupancy tracking**: pointers are log2(DEPTH)+1 bits. Full or empty is decided by MSB difference with equal low bits.

## Structure

- **Shared package seq_det_pkg**
  - Default TS_WIDTH, DEPTH and CNT_WIDTH.
  - The detector's state-encoding constants (S0..S3), so detector and logger benches share them.
- **Sub-module sync_fifo**
  - Parameterised on WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Owns the "simultaneous push/pop when full" rule.
- **Top level** holds ts, total_cnt, overflow, the clr/rst muxing, and the drop decision.

## Test plan

- **Basic capture**: rst 2 cycles, en=1; det pulse when ts=5, rd_ready=0 → rd_valid=1 and rd_ts=5 next cycle; total_cnt=1.
- **Drive from fsm1011**: x stream 1011011 → two det pulses, 3 cycles apart → two entries, timestamps differ by 3; popped in order.
- **Overflow**: rd_ready=0; 5 det pulses with DEPTH=4 → FIFO holds the first 4 timestamps, overflow=1, total_cnt=5.
- **Push+pop while full**: FIFO full, det=1 and rd_ready=1 in the same cycle → overflow stays 0, occupancy stays 4, new timestamp lands at the tail.
- **Saturation and wrap**
  - CNT_WIDTH=2: 5 detections → total_cnt=3.
  - TS_WIDTH=4: det at ts=15, then next cycle at ts=0 → entries 15, 0.
- **Clear mid-operation**
  - clr asserted together with det and rd_ready while 3 entries are pending → next cycle rd_valid=0, total_cnt=0, overflow=0, ts=0, with no capture.
  - rst behaves identically.
